// File: rtl/otter_ir_pipe.sv
// ---------------------------------------------------------------------------
// otter_ir_pipe
//
// Purpose:
//   Instruction-register pipeline for a 5-stage OTTER core (DEC/EXE/MEM/WB).
//   It moves instruction words down the pipe and inserts NOP bubbles on
//   flushes and load-use hazards. It also freezes on an external hold.
//   Priority of the per-edge action: HOLD > CLEAR > load-use bubble > advance.
//
// Ports:
//   CLK          in   1   rising-edge clock
//   RST_N        in   1   asynchronous active-low reset
//   FETCH_IR     in  32   instruction word from instruction memory
//   FETCH_VALID  in   1   FETCH_IR is valid this cycle
//   HOLD         in   1   external freeze; every stage holds
//   CLEAR        in   1   taken branch/jump resolved in EXE; flush DEC/EXE
//   DEC_IR       out 32   decode-stage instruction register
//   EXE_IR       out 32   execute-stage instruction register
//   MEM_IR       out 32   memory-stage instruction register
//   WB_IR        out 32   write-back-stage instruction register
//   PC_STALL     out  1   combinational; PC and fetch hold this cycle
//   HAZARD       out  1   combinational; load-use hazard detected
//   STALL_COUNT  out 16   saturating count of load-use bubbles inserted
//
// Configuration macro:
//   OTTER_IR_PIPE_LOADUSE_STALL_EN
//     - defined   : load-use detection, bubble insertion and STALL_COUNT
//     - undefined : HAZARD and STALL_COUNT are tied to 0; software must
//                   schedule around loads
// ---------------------------------------------------------------------------
module otter_ir_pipe (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] FETCH_IR,
    input  logic        FETCH_VALID,
    input  logic        HOLD,
    input  logic        CLEAR,
    output logic [31:0] DEC_IR,
    output logic [31:0] EXE_IR,
    output logic [31:0] MEM_IR,
    output logic [31:0] WB_IR,
    output logic        PC_STALL,
    output logic        HAZARD,
    output logic [15:0] STALL_COUNT
);

    // addi x0,x0,0 -- used for every bubble and flushed slot
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    // Action taken at the next clock edge
    typedef enum logic [1:0] {
        ADV_NORMAL = 2'b00,
        ADV_BUBBLE = 2'b01,
        ADV_FLUSH  = 2'b10,
        ADV_HOLD   = 2'b11
    } adv_e;

    logic [31:0] dec_q, dec_d;
    logic [31:0] exe_q, exe_d;
    logic [31:0] mem_q, mem_d;
    logic [31:0] wb_q,  wb_d;
    logic        load_use_s;
    adv_e        adv_s;

`ifdef OTTER_IR_PIPE_LOADUSE_STALL_EN
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    // True when the instruction reads its rs1 field as a register.
    // CSR immediate forms (func3[2]=1) carry a zimm there instead.
    function automatic logic uses_rs1_f(input logic [31:0] ir);
        logic r;
        case (ir[6:0])
            OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP: r = 1'b1;
            OPC_SYSTEM:                    r = ~ir[14];
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // True when the instruction reads its rs2 field as a register
    function automatic logic uses_rs2_f(input logic [31:0] ir);
        logic r;
        case (ir[6:0])
            OPC_BRANCH, OPC_STORE, OPC_OP: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    logic [15:0] stall_count_q, stall_count_d;

    // Load in EXE writing a non-zero rd that the DEC instruction reads
    always_comb begin
        load_use_s = 1'b0;
        if ((exe_q[6:0] == OPC_LOAD) && (exe_q[11:7] != 5'd0)) begin
            if (((exe_q[11:7] == dec_q[19:15]) && uses_rs1_f(dec_q)) ||
                ((exe_q[11:7] == dec_q[24:20]) && uses_rs2_f(dec_q))) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = 1'b0;
            end
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Bubble counter next state; saturates instead of wrapping
    always_comb begin
        stall_count_d = stall_count_q;
        if ((adv_s == ADV_BUBBLE) && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Bubble counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_count_q <= 16'h0000;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign STALL_COUNT = stall_count_q;
`else
    assign load_use_s  = 1'b0;
    assign STALL_COUNT = 16'h0000;
`endif

    // Select the per-edge action by priority
    always_comb begin
        adv_s = ADV_NORMAL;
        if (HOLD) begin
            adv_s = ADV_HOLD;
        end else if (CLEAR) begin
            adv_s = ADV_FLUSH;
        end else if (load_use_s) begin
            adv_s = ADV_BUBBLE;
        end else begin
            adv_s = ADV_NORMAL;
        end
    end

    // Next-state of the four instruction registers
    always_comb begin
        dec_d = dec_q;
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        case (adv_s)
            ADV_HOLD: begin
                dec_d = dec_q;
                exe_d = exe_q;
                mem_d = mem_q;
                wb_d  = wb_q;
            end
            ADV_FLUSH: begin
                dec_d = NOP_IR;
                exe_d = NOP_IR;
                mem_d = exe_q;
                wb_d  = mem_q;
            end
            ADV_BUBBLE: begin
                dec_d = dec_q;
                exe_d = NOP_IR;
                mem_d = exe_q;
                wb_d  = mem_q;
            end
            ADV_NORMAL: begin
                dec_d = FETCH_VALID ? FETCH_IR : NOP_IR;
                exe_d = dec_q;
                mem_d = exe_q;
                wb_d  = mem_q;
            end
            default: begin
                dec_d = dec_q;
                exe_d = exe_q;
                mem_d = mem_q;
                wb_d  = wb_q;
            end
        endcase
    end

    // Instruction registers; reset fills every stage with NOP
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dec_q <= NOP_IR;
            exe_q <= NOP_IR;
            mem_q <= NOP_IR;
            wb_q  <= NOP_IR;
        end else begin
            dec_q <= dec_d;
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Reset gating keeps PC_STALL low even if HOLD is driven during reset
    assign HAZARD   = RST_N & load_use_s;
    assign PC_STALL = RST_N & ((adv_s == ADV_HOLD) | (adv_s == ADV_BUBBLE));

    assign DEC_IR = dec_q;
    assign EXE_IR = exe_q;
    assign MEM_IR = mem_q;
    assign WB_IR  = wb_q;

endmodule

// File: tb/tb_otter_ir_pipe.sv
// ---------------------------------------------------------------------------
// tb_otter_ir_pipe
//
// Self-checking bench for otter_ir_pipe. A cycle table drives HOLD/CLEAR/
// fetch and gives the expected HAZARD (as it should be with load-use
// detection enabled). A small pipe model predicts the four IRs and
// STALL_COUNT after each edge. Predictions go into a scoreboard queue and are
// compared on the following negedge. Follows OTTER_IR_PIPE_LOADUSE_STALL_EN
// the same way the design does.
// ---------------------------------------------------------------------------
module tb_otter_ir_pipe;

`ifdef OTTER_IR_PIPE_LOADUSE_STALL_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD5  = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] LW0   = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD0  = 32'h0020_0333; // add  x6,x0,x2
    localparam logic [31:0] ADDR2 = 32'h0051_0333; // add  x6,x2,x5
    localparam logic [31:0] LUI   = 32'h0002_80B7; // lui  (rs1 field = 5)
    localparam logic [31:0] CSRI  = 32'h3002_D073; // csrrwi (zimm = 5)
    localparam logic [31:0] CSRR  = 32'h3002_9073; // csrrw x0,0x300,x5
    localparam logic [31:0] BEQ   = 32'h0020_8463; // beq  x1,x2,8

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] FETCH_IR = 32'h0;
    logic        FETCH_VALID = 1'b0;
    logic        HOLD = 1'b0;
    logic        CLEAR = 1'b0;
    logic [31:0] DEC_IR, EXE_IR, MEM_IR, WB_IR;
    logic        PC_STALL, HAZARD;
    logic [15:0] STALL_COUNT;
    bit          clk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    otter_ir_pipe dut (
        .CLK(CLK), .RST_N(RST_N), .FETCH_IR(FETCH_IR), .FETCH_VALID(FETCH_VALID),
        .HOLD(HOLD), .CLEAR(CLEAR), .DEC_IR(DEC_IR), .EXE_IR(EXE_IR),
        .MEM_IR(MEM_IR), .WB_IR(WB_IR), .PC_STALL(PC_STALL), .HAZARD(HAZARD),
        .STALL_COUNT(STALL_COUNT)
    );

    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        hold;
        logic        clear;
        logic        valid;
        logic [31:0] ir;
        logic        hz;
    } vec_t;

    typedef struct {
        logic [31:0] dec, exe, mem, wb;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    logic [31:0] m_dec = NOP, m_exe = NOP, m_mem = NOP, m_wb = NOP;
    logic [15:0] m_cnt = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic rd_rs1(input logic [31:0] ir);
        logic [6:0] op = ir[6:0];
        return (op == 7'h67) || (op == 7'h63) || (op == 7'h03) || (op == 7'h23) ||
               (op == 7'h13) || (op == 7'h33) || ((op == 7'h73) && (ir[14] == 1'b0));
    endfunction

    function automatic logic rd_rs2(input logic [31:0] ir);
        logic [6:0] op = ir[6:0];
        return (op == 7'h63) || (op == 7'h23) || (op == 7'h33);
    endfunction

    function automatic logic m_hz();
        logic [4:0] rd = m_exe[11:7];
        return LU_EN && (m_exe[6:0] == 7'h03) && (rd != 5'd0) &&
               (((rd == m_dec[19:15]) && rd_rs1(m_dec)) ||
                ((rd == m_dec[24:20]) && rd_rs2(m_dec)));
    endfunction

    function automatic vec_t mk(input logic h, c, v, input logic [31:0] ir, input logic hz);
        vec_t r;
        r.hold = h; r.clear = c; r.valid = v; r.ir = ir; r.hz = hz;
        return r;
    endfunction

    task automatic model_reset();
        m_dec = NOP; m_exe = NOP; m_mem = NOP; m_wb = NOP; m_cnt = 16'h0;
    endtask

    // One clock: drive at negedge, check comb outputs, predict, compare after edge
    task automatic step(input logic h, c, v, input logic [31:0] ir,
                        input logic ehz, input string tag);
        exp_t e;
        logic ps;
        HOLD = h; CLEAR = c; FETCH_VALID = v; FETCH_IR = ir;
        #1;
        ps = h | (~c & ehz);
        chk({tag, " HAZARD"},   32'(HAZARD),   32'(ehz));
        chk({tag, " PC_STALL"}, 32'(PC_STALL), 32'(ps));
        e.dec = m_dec; e.exe = m_exe; e.mem = m_mem; e.wb = m_wb; e.cnt = m_cnt;
        if (h) begin
            // everything holds
        end else if (c) begin
            e.wb = m_mem; e.mem = m_exe; e.exe = NOP; e.dec = NOP;
        end else if (ehz) begin
            e.wb = m_mem; e.mem = m_exe; e.exe = NOP;
            if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
        end else begin
            e.wb = m_mem; e.mem = m_exe; e.exe = m_dec; e.dec = v ? ir : NOP;
        end
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        e = sb.pop_front();
        chk({tag, " DEC_IR"}, DEC_IR, e.dec);
        chk({tag, " EXE_IR"}, EXE_IR, e.exe);
        chk({tag, " MEM_IR"}, MEM_IR, e.mem);
        chk({tag, " WB_IR"},  WB_IR,  e.wb);
        chk({tag, " STALL_COUNT"}, 32'(STALL_COUNT), 32'(e.cnt));
        m_dec = e.dec; m_exe = e.exe; m_mem = e.mem; m_wb = e.wb; m_cnt = e.cnt;
    endtask

    initial begin
        vec_t vt[34];
        logic [31:0] prog[6];
        int fp;
        logic hz;

        // Cycle table; hz column is the expected HAZARD with detection on
        vt[0]  = mk(0, 0, 1, LW5,   0);
        vt[1]  = mk(0, 0, 1, ADD5,  0);
        vt[2]  = mk(0, 0, 1, ADD5,  1); // load-use on rs1
        vt[3]  = mk(0, 0, 0, NOP,   0);
        vt[4]  = mk(0, 0, 1, LW0,   0);
        vt[5]  = mk(0, 0, 1, ADD0,  0);
        vt[6]  = mk(0, 0, 0, NOP,   0); // rd == x0: no hazard
        vt[7]  = mk(0, 0, 1, LW5,   0);
        vt[8]  = mk(0, 0, 1, ADD0,  0);
        vt[9]  = mk(0, 0, 0, NOP,   0); // no dependence
        vt[10] = mk(0, 0, 1, LW5,   0);
        vt[11] = mk(0, 0, 1, ADDR2, 0);
        vt[12] = mk(0, 0, 1, ADDR2, 1); // load-use on rs2
        vt[13] = mk(0, 0, 1, LW5,   0);
        vt[14] = mk(0, 0, 1, LUI,   0);
        vt[15] = mk(0, 0, 1, LW5,   0); // LUI does not read rs1
        vt[16] = mk(0, 0, 1, CSRI,  0);
        vt[17] = mk(0, 0, 1, LW5,   0); // CSR immediate form: no rs1 read
        vt[18] = mk(0, 0, 1, CSRR,  0);
        vt[19] = mk(0, 0, 1, CSRR,  1); // CSR register form reads rs1
        vt[20] = mk(0, 0, 0, NOP,   0);
        vt[21] = mk(0, 0, 1, BEQ,   0);
        vt[22] = mk(0, 0, 1, ADD0,  0);
        vt[23] = mk(0, 1, 1, LW5,   0); // flush with branch in EXE
        vt[24] = mk(0, 0, 1, LW5,   0);
        vt[25] = mk(0, 0, 1, ADD5,  0);
        vt[26] = mk(0, 1, 1, ADD5,  1); // CLEAR beats HAZARD
        vt[27] = mk(0, 0, 1, LW5,   0);
        vt[28] = mk(0, 0, 1, ADD5,  0);
        vt[29] = mk(1, 1, 1, ADD5,  1); // HOLD beats CLEAR and HAZARD
        vt[30] = mk(1, 1, 1, ADD5,  1);
        vt[31] = mk(1, 1, 1, ADD5,  1);
        vt[32] = mk(0, 1, 1, ADD5,  1); // release: flush applies
        vt[33] = mk(0, 0, 0, NOP,   0);

        // Asynchronous reset with the clock stopped
        #2;
        HOLD = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("reset DEC_IR", DEC_IR, NOP);
        chk("reset EXE_IR", EXE_IR, NOP);
        chk("reset MEM_IR", MEM_IR, NOP);
        chk("reset WB_IR",  WB_IR,  NOP);
        chk("reset STALL_COUNT", 32'(STALL_COUNT), 32'h0);
        chk("reset PC_STALL", 32'(PC_STALL), 32'h0);
        chk("reset HAZARD",   32'(HAZARD),   32'h0);
        clk_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        HOLD = 1'b0;
        model_reset();

        for (int i = 0; i < 34; i++) begin
            step(vt[i].hold, vt[i].clear, vt[i].valid, vt[i].ir,
                 LU_EN ? vt[i].hz : 1'b0, $sformatf("vec%0d", i));
        end

`ifdef OTTER_IR_PIPE_LOADUSE_STALL_EN
        // Preload the counter near saturation while the pipe is frozen
        HOLD = 1'b1;
        CLEAR = 1'b0;
        force dut.stall_count_q = 16'hFFFE;
        @(posedge CLK);
        @(negedge CLK);
        release dut.stall_count_q;
        HOLD = 1'b0;
        m_cnt = 16'hFFFE;
        #1;
        chk("preload STALL_COUNT", 32'(STALL_COUNT), 32'h0000_FFFE);
`endif

        // Load-use stream: three hazards with detection on, none with it off
        prog[0] = LW5; prog[1] = ADD5; prog[2] = LW5;
        prog[3] = ADD5; prog[4] = LW5; prog[5] = ADD5;
        fp = 0;
        for (int k = 0; k < 14; k++) begin
            hz = m_hz();
            if (fp < 6) step(1'b0, 1'b0, 1'b1, prog[fp], hz, $sformatf("sat%0d", k));
            else        step(1'b0, 1'b0, 1'b0, NOP,      hz, $sformatf("sat%0d", k));
            if (!hz && fp < 6) fp++;
        end
`ifdef OTTER_IR_PIPE_LOADUSE_STALL_EN
        chk("saturated STALL_COUNT", 32'(STALL_COUNT), 32'h0000_FFFF);
`else
        chk("disabled STALL_COUNT", 32'(STALL_COUNT), 32'h0);
`endif

        // Reset in the middle of a pending load-use stall
        step(1'b0, 1'b0, 1'b1, LW5,  m_hz(), "mid0");
        step(1'b0, 1'b0, 1'b1, ADD5, m_hz(), "mid1");
        HOLD = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("midrst DEC_IR", DEC_IR, NOP);
        chk("midrst EXE_IR", EXE_IR, NOP);
        chk("midrst MEM_IR", MEM_IR, NOP);
        chk("midrst WB_IR",  WB_IR,  NOP);
        chk("midrst STALL_COUNT", 32'(STALL_COUNT), 32'h0);
        chk("midrst PC_STALL", 32'(PC_STALL), 32'h0);
        chk("midrst HAZARD",   32'(HAZARD),   32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b1, LW0, 1'b0, "postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/otter_ir_pipe.md
OTTER_IR_PIPE -- requirements
Module: otter_ir_pipe

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: CLK and RST_N.
REQ-002 The module SHALL expose these ports (name  direction  width  meaning):
- CLK  in  1  rising-edge clock
- RST_N  in  1  async active-low reset
- FETCH_IR  in  32  instruction word from instruction memory
- FETCH_VALID  in  1  FETCH_IR holds a valid instruction this cycle
- HOLD  in  1  external freeze (memory wait); all stages hold
- CLEAR  in  1  taken branch/jump resolved in EXE; flush younger stages
- DEC_IR, EXE_IR, MEM_IR, WB_IR  out  32  per-stage instruction registers, consumed by the control decoder
- PC_STALL  out  1  comb; PC and fetch SHALL hold this cycle
- HAZARD  out  1  comb; load-use hazard detected this cycle
- STALL_COUNT  out  16  count of hazard bubbles inserted

Function
REQ-003 NOP SHALL be 32'h00000013 (addi x0,x0,0); every bubble and flushed slot SHALL hold NOP.
REQ-004 Normal advance (no HOLD, no CLEAR, no HAZARD), at each edge: WB_IR<=MEM_IR, MEM_IR<=EXE_IR, EXE_IR<=DEC_IR, DEC_IR<=FETCH_VALID ? FETCH_IR : NOP.
REQ-005 rs1-user opcodes SHALL be JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM when func3[2]==0; rs2-user opcodes SHALL be BRANCH, STORE, OP.
REQ-006 HAZARD SHALL be 1 when all of the following hold:
- EXE_IR[6:0]==7'b0000011;
- EXE_IR[11:7]!=0;
- that rd equals DEC_IR[19:15] and DEC_IR's opcode uses rs1, or equals DEC_IR[24:20] and DEC_IR's opcode uses rs2.
REQ-007 On a HAZARD cycle (no HOLD, no CLEAR), at the edge:
- DEC_IR SHALL hold;
- EXE_IR SHALL load NOP;
- MEM_IR and WB_IR SHALL advance;
- PC_STALL SHALL be 1.
A hazard SHALL insert exactly one bubble.
REQ-008 On a CLEAR cycle (no HOLD), at the edge:
- DEC_IR and EXE_IR SHALL load NOP;
- MEM_IR and WB_IR SHALL advance;
- HAZARD-induced stalling SHALL be suppressed;
- PC_STALL SHALL be 0.
REQ-009 On a HOLD cycle, all four IR registers and STALL_COUNT SHALL hold and PC_STALL SHALL be 1, regardless of CLEAR or HAZARD.
REQ-010 Priority SHALL be HOLD > CLEAR > HAZARD > normal advance.
REQ-011 STALL_COUNT SHALL increment by 1 on each edge where REQ-007 applies, and SHALL saturate at 16'hFFFF.
REQ-012 PC_STALL SHALL be 1 only under REQ-007 or REQ-009.

Reset
REQ-013 On RST_N low, all IR outputs SHALL become NOP and STALL_COUNT SHALL become 0 immediately, without waiting for a clock edge.
REQ-014 While RST_N is low, HAZARD and PC_STALL SHALL be 0.
REQ-015 Reset asserted mid-stall or mid-flush SHALL abandon that operation; the first edge after deassertion SHALL perform a normal advance.

Configuration
REQ-016 Macro OTTER_IR_PIPE_LOADUSE_STALL_EN SHALL control load-use detection:
- Defined: REQ-006, REQ-007 and REQ-011 apply.
- Undefined: HAZARD SHALL be tied to 0, STALL_COUNT SHALL be tied to 0, and no load-use stall SHALL occur (software schedules loads).

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset: drop RST_N with no clock -> all IRs 0x00000013, STALL_COUNT=0.
- Load-use: fetch lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333) -> HAZARD=1 and PC_STALL=1 for 1 cycle; EXE_IR=NOP next cycle; add reaches EXE one cycle later; STALL_COUNT=1.
- Rd x0 and no dependence: lw x0,0(x1) (0x0000A003) then add x6,x0,x2 (0x00200333) -> HAZARD=0, no bubble; repeat with lw x5 then 0x00200333 -> HAZARD=0.
- Flush: CLEAR=1 while EXE holds a BRANCH -> next edge DEC_IR=EXE_IR=NOP and branch in MEM_IR; CLEAR and HAZARD together -> flush wins, PC_STALL=0, STALL_COUNT unchanged.
- Hold: HOLD=1 for 3 cycles with CLEAR=1 -> all IRs and STALL_COUNT unchanged, PC_STALL=1; release -> CLEAR flush applied.
- Saturation: preload STALL_COUNT to 0xFFFE, run 3 hazards -> count stays 0xFFFF; macro undefined -> same load-use stream gives HAZARD=0 throughout.
